// File: rtl/gc_sweep_ctrl_if.sv
// Driver/consumer bundle between the sweep controller and its datapath/host side.
// The controller uses the slave modport; the host and datapath model use master.
interface gc_sweep_ctrl_if #(
  parameter int PRECISION_BITS  = 4,
  parameter int OVERFLOW_BITS   = 4,
  parameter int NUM_NODES       = 4,
  parameter int NUM_NODES_BIT   = 2,
  parameter int NUM_COLORS_BITS = 2,
  parameter int SWEEP_BITS      = 16
);
  localparam int PAD  = PRECISION_BITS + OVERFLOW_BITS;
  localparam int CB_W = (NUM_COLORS_BITS > 1) ? $clog2(NUM_COLORS_BITS) : 1;
  localparam int NB   = NUM_NODES * NUM_COLORS_BITS;

  logic                      load;
  logic [NB-1:0]             init_nodes;
  logic                      start;
  logic [SWEEP_BITS-1:0]     num_sweeps;
  logic signed [PAD:0]       noise;
  logic signed [PAD-1:0]     product;
  logic [NUM_NODES_BIT-1:0]  node_count;
  logic [CB_W-1:0]           color_bit_count;
  logic [NB-1:0]             nodes;
  logic                      busy;
  logic                      done;
  logic [SWEEP_BITS-1:0]     sweep_count;

  modport master (
    output load, init_nodes, start, num_sweeps, noise, product,
    input  node_count, color_bit_count, nodes, busy, done, sweep_count
  );

  modport slave (
    input  load, init_nodes, start, num_sweeps, noise, product,
    output node_count, color_bit_count, nodes, busy, done, sweep_count
  );
endinterface

// File: rtl/gc_sweep_ctrl.sv
// Gibbs-style sweep controller: 2 cycles per colour bit (EVAL, WRITE) plus 1 FIX cycle per node.
// No backpressure: product and noise are taken as valid whenever EVAL/WRITE sample them.
module gc_sweep_ctrl #(
  parameter int PRECISION_BITS  = 4,
  parameter int OVERFLOW_BITS   = 4,
  parameter int NUM_NODES       = 4,
  parameter int NUM_NODES_BIT   = 2,
  parameter int NUM_COLORS      = 4,
  parameter int NUM_COLORS_BITS = 2,
  parameter int SWEEP_BITS      = 16
) (
  input  logic           clk,
  input  logic           rst,
  gc_sweep_ctrl_if.slave bus
);
  localparam int B     = NUM_COLORS_BITS;
  localparam int PAD   = PRECISION_BITS + OVERFLOW_BITS;
  localparam int CB_W  = (B > 1) ? $clog2(B) : 1;
  localparam int NB    = NUM_NODES * B;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [B-1:0] CLAMP = B'(NUM_COLORS - 1);

  typedef enum logic [2:0] {IDLE, EVAL, WRITE, FIX, DONE} state_t;

  state_t                   state_q, state_d;
  logic [NB-1:0]            nodes_q, nodes_d;
  logic [NUM_NODES_BIT-1:0] node_count_q, node_count_d;
  logic [CB_W-1:0]          color_bit_count_q, color_bit_count_d;
  logic [SWEEP_BITS-1:0]    sweep_count_q, sweep_count_d;
  logic [SWEEP_BITS-1:0]    num_sweeps_q, num_sweeps_d;
  logic signed [PAD-1:0]    field_q, field_d;

  logic signed [PAD+1:0]    sum;
  logic                     wr_bit;
  logic [IDX_W-1:0]         bit_idx;
  logic [IDX_W-1:0]         node_base;
  logic [B-1:0]             cur_color;
  logic [SWEEP_BITS-1:0]    sweep_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= IDLE;
      nodes_q           <= '0;
      node_count_q      <= '0;
      color_bit_count_q <= '0;
      sweep_count_q     <= '0;
      num_sweeps_q      <= '0;
      field_q           <= '0;
    end else begin
      state_q           <= state_d;
      nodes_q           <= nodes_d;
      node_count_q      <= node_count_d;
      color_bit_count_q <= color_bit_count_d;
      sweep_count_q     <= sweep_count_d;
      num_sweeps_q      <= num_sweeps_d;
      field_q           <= field_d;
    end
  end

  always_comb begin
    // Two guard bits: sign-extended field plus 9-bit noise can never wrap.
    sum       = {{2{field_q[PAD-1]}}, field_q} + {bus.noise[PAD], bus.noise};
    wr_bit    = !sum[PAD+1] && (sum != '0);
    bit_idx   = IDX_W'(int'(node_count_q) * B + int'(color_bit_count_q));
    node_base = IDX_W'(int'(node_count_q) * B);
    cur_color = nodes_q[node_base +: B];
    sweep_inc = sweep_count_q + SWEEP_BITS'(1);

    state_d           = state_q;
    nodes_d           = nodes_q;
    node_count_d      = node_count_q;
    color_bit_count_d = color_bit_count_q;
    sweep_count_d     = sweep_count_q;
    num_sweeps_d      = num_sweeps_q;
    field_d           = field_q;

    case (state_q)
      IDLE: begin
        if (bus.load) begin
          nodes_d = bus.init_nodes;
        end else if (bus.start) begin
          num_sweeps_d      = bus.num_sweeps;
          sweep_count_d     = '0;
          node_count_d      = '0;
          color_bit_count_d = '0;
          state_d           = (bus.num_sweeps == '0) ? DONE : EVAL;
        end
      end
      EVAL: begin
        field_d = bus.product;
        state_d = WRITE;
      end
      WRITE: begin
        nodes_d[bit_idx] = wr_bit;
        if (int'(color_bit_count_q) < B - 1) begin
          color_bit_count_d = color_bit_count_q + CB_W'(1);
          state_d           = EVAL;
        end else begin
          state_d = FIX;
        end
      end
      FIX: begin
        if (int'(cur_color) >= NUM_COLORS) nodes_d[node_base +: B] = CLAMP;
        color_bit_count_d = '0;
        if (int'(node_count_q) < NUM_NODES - 1) begin
          node_count_d = node_count_q + NUM_NODES_BIT'(1);
          state_d      = EVAL;
        end else begin
          node_count_d  = '0;
          sweep_count_d = sweep_inc;
          state_d       = (sweep_inc == num_sweeps_q) ? DONE : EVAL;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.nodes           = nodes_q;
  assign bus.node_count      = node_count_q;
  assign bus.color_bit_count = color_bit_count_q;
  assign bus.sweep_count     = sweep_count_q;
  assign bus.busy            = (state_q == EVAL) || (state_q == WRITE) || (state_q == FIX);
  assign bus.done            = (state_q == DONE);
endmodule

// File: tb/tb_gc_sweep_ctrl.sv
// Bench for gc_sweep_ctrl: one instance with 4 legal colours, one with 3, driven in lockstep.
module tb_gc_sweep_ctrl;
  logic clk;
  logic rst;
  logic load, start, rand_mode;
  logic [7:0] init_v;
  logic [15:0] nsw;
  logic signed [7:0] const_p;
  logic signed [8:0] const_n;

  int checks = 0;
  int errors = 0;

  int wt [4][2];
  logic signed [8:0] nt [4][4][2];

  gc_sweep_ctrl_if bus4 ();
  gc_sweep_ctrl_if bus3 ();

  gc_sweep_ctrl #(.NUM_COLORS(4)) dut  (.clk(clk), .rst(rst), .bus(bus4));
  gc_sweep_ctrl #(.NUM_COLORS(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  // Stand-in datapath: field depends on the live colour vector, so write order matters.
  function automatic logic signed [7:0] dp(input logic [7:0] nv, input logic [1:0] n, input logic b);
    int v;
    v = wt[n][b] - 3 * $countones(nv) + 12;
    return 8'(v);
  endfunction

  assign bus4.load       = load;
  assign bus3.load       = load;
  assign bus4.start      = start;
  assign bus3.start      = start;
  assign bus4.init_nodes = init_v;
  assign bus3.init_nodes = init_v;
  assign bus4.num_sweeps = nsw;
  assign bus3.num_sweeps = nsw;
  assign bus4.product = rand_mode ? dp(bus4.nodes, bus4.node_count, bus4.color_bit_count[0]) : const_p;
  assign bus3.product = rand_mode ? dp(bus3.nodes, bus3.node_count, bus3.color_bit_count[0]) : const_p;
  assign bus4.noise = rand_mode ? nt[bus4.sweep_count[1:0]][bus4.node_count][bus4.color_bit_count[0]] : const_n;
  assign bus3.noise = rand_mode ? nt[bus3.sweep_count[1:0]][bus3.node_count][bus3.color_bit_count[0]] : const_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, want);
    end
  endtask

  // Reference: walk sweeps/nodes/bits in order, deciding each bit from the field of the current vector.
  function automatic logic [7:0] model(input logic [7:0] start_v, input int s, input int nc);
    logic [7:0] nv;
    int p, sm;
    nv = start_v;
    for (int sw = 0; sw < s; sw++)
      for (int n = 0; n < 4; n++) begin
        for (int b = 0; b < 2; b++) begin
          p  = dp(nv, 2'(n), 1'(b));
          sm = p + int'(nt[sw % 4][n][b]);
          nv[2*n + b] = (sm > 0);
        end
        if (int'(nv[2*n +: 2]) >= nc) nv[2*n +: 2] = 2'(nc - 1);
      end
    return nv;
  endfunction

  // Optional load, then start; returns the cycle done was seen (-1 on timeout) and busy-cycle count.
  task automatic run(input logic [7:0] iv, input int s, input bit do_load, input bit glitch,
                     output int done_cyc, output int busy_cyc);
    if (do_load) begin
      @(negedge clk);
      load = 1'b1;
      init_v = iv;
      @(negedge clk);
      load = 1'b0;
      init_v = 8'h3C;
      chk("load_nodes4", 32'(bus4.nodes), 32'(iv));
      chk("load_nodes3", 32'(bus3.nodes), 32'(iv));
    end else begin
      @(negedge clk);
    end
    nsw = 16'(s);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nsw = 16'hFFFF;
    done_cyc = -1;
    busy_cyc = 0;
    for (int c = 1; c <= 300 && done_cyc < 0; c++) begin
      if (bus4.busy) busy_cyc++;
      if (bus4.done) done_cyc = c;
      if (glitch && (c == 5 || c == 12)) begin
        load = 1'b1;
        start = 1'b1;
        init_v = 8'h33;
      end else begin
        load = 1'b0;
        start = 1'b0;
      end
      @(negedge clk);
    end
    load = 1'b0;
    start = 1'b0;
    chk("done_is_pulse", 32'(bus4.done), 32'd0);
    chk("idle_not_busy", 32'(bus4.busy), 32'd0);
    chk("sweep_count_held", 32'(bus4.sweep_count), 32'(s));
  endtask

  typedef struct {
    logic signed [7:0] p;
    logic signed [8:0] n;
    logic [7:0]        iv;
    int                s;
    logic [7:0]        want4;
    logic [7:0]        want3;
    int                want_done;
  } vec_t;

  vec_t vt [8];
  int dc, bc;
  logic [7:0] r_init;
  int r_s;

  initial begin
    vt[0] = '{8'sd5,    9'sd0,   8'h00, 1, 8'hFF, 8'hAA, 21};
    vt[1] = '{-8'sd1,   9'sd0,   8'hFF, 2, 8'h00, 8'h00, 41};
    vt[2] = '{8'sd2,    -9'sd2,  8'hFF, 1, 8'h00, 8'h00, 21};
    vt[3] = '{8'sd2,    -9'sd1,  8'h00, 1, 8'hFF, 8'hAA, 21};
    vt[4] = '{8'sd127,  9'sd255, 8'h00, 1, 8'hFF, 8'hAA, 21};
    vt[5] = '{-8'sd128, 9'sd127, 8'hFF, 1, 8'h00, 8'h00, 21};
    vt[6] = '{8'sd0,    9'sd1,   8'h00, 3, 8'hFF, 8'hAA, 61};
    vt[7] = '{8'sd5,    9'sd0,   8'h5A, 0, 8'h5A, 8'h5A, 1};

    load = 1'b0; start = 1'b0; rand_mode = 1'b0;
    init_v = 8'h00; nsw = 16'd0; const_p = 8'sd0; const_n = 9'sd0;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 2; j++) wt[i][j] = 0;
    for (int a = 0; a < 4; a++) for (int i = 0; i < 4; i++) for (int j = 0; j < 2; j++) nt[a][i][j] = 9'sd0;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_nodes", 32'(bus4.nodes), 32'd0);
    chk("rst_busy", 32'(bus4.busy), 32'd0);
    chk("rst_done", 32'(bus4.done), 32'd0);
    chk("rst_sweep", 32'(bus4.sweep_count), 32'd0);
    chk("rst_node_count", 32'(bus4.node_count), 32'd0);
    chk("rst_cbit", 32'(bus4.color_bit_count), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      const_p = vt[i].p;
      const_n = vt[i].n;
      run(vt[i].iv, vt[i].s, 1'b1, 1'b0, dc, bc);
      chk($sformatf("vec%0d_nodes4", i), 32'(bus4.nodes), 32'(vt[i].want4));
      chk($sformatf("vec%0d_nodes3", i), 32'(bus3.nodes), 32'(vt[i].want3));
      chk($sformatf("vec%0d_done_cycle", i), 32'(dc), 32'(vt[i].want_done));
      chk($sformatf("vec%0d_busy_cycles", i), 32'(bc), 32'(vt[i].want_done - 1));
    end

    // start/load pulsed mid-run must not disturb the result or timing
    const_p = 8'sd5;
    const_n = 9'sd0;
    run(8'h00, 1, 1'b1, 1'b1, dc, bc);
    chk("glitch_nodes4", 32'(bus4.nodes), 32'hFF);
    chk("glitch_nodes3", 32'(bus3.nodes), 32'hAA);
    chk("glitch_done_cycle", 32'(dc), 32'd21);

    // step-level walk and asynchronous reset in cycle 7
    @(negedge clk);
    load = 1'b1; init_v = 8'h00;
    @(negedge clk);
    load = 1'b0; nsw = 16'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("c1_busy", 32'(bus4.busy), 32'd1);
    repeat (2) @(negedge clk);
    chk("c3_nodes", 32'(bus4.nodes), 32'h01);
    chk("c3_cbit", 32'(bus4.color_bit_count), 32'd1);
    repeat (3) @(negedge clk);
    chk("c6_node_count", 32'(bus4.node_count), 32'd1);
    chk("c6_cbit", 32'(bus4.color_bit_count), 32'd0);
    @(negedge clk);
    chk("c7_nodes", 32'(bus4.nodes), 32'h03);
    #1 rst = 1'b1;
    #1;
    chk("arst_nodes", 32'(bus4.nodes), 32'd0);
    chk("arst_busy", 32'(bus4.busy), 32'd0);
    chk("arst_node_count", 32'(bus4.node_count), 32'd0);
    chk("arst_done", 32'(bus4.done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run(8'h00, 1, 1'b0, 1'b0, dc, bc);
    chk("post_rst_nodes4", 32'(bus4.nodes), 32'hFF);
    chk("post_rst_nodes3", 32'(bus3.nodes), 32'hAA);
    chk("post_rst_done_cycle", 32'(dc), 32'd21);

    // randomized weights and noise against the sequential reference
    rand_mode = 1'b1;
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 4; i++) for (int j = 0; j < 2; j++) wt[i][j] = int'($urandom_range(0, 40)) - 20;
      for (int a = 0; a < 4; a++) for (int i = 0; i < 4; i++) for (int j = 0; j < 2; j++)
        nt[a][i][j] = 9'(int'($urandom_range(0, 60)) - 30);
      r_init = 8'($urandom);
      r_s = int'($urandom_range(1, 3));
      run(r_init, r_s, 1'b1, 1'b0, dc, bc);
      chk($sformatf("rand%0d_nodes4", t), 32'(bus4.nodes), 32'(model(r_init, r_s, 4)));
      chk($sformatf("rand%0d_nodes3", t), 32'(bus3.nodes), 32'(model(r_init, r_s, 3)));
      chk($sformatf("rand%0d_done_cycle", t), 32'(dc), 32'(1 + 20 * r_s));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gc_sweep_ctrl.md
# gc_sweep_ctrl

Sequential sweep controller for the graph-colouring accelerator: the consumer and driver side of the combinational `vecmul_gc` local-field datapath. It owns the node colour register and steps `node_count` / `color_bit_count` through every node and colour bit. Each step captures the returned field `product`, adds external noise and writes the decided bit back into the colour register. It runs a programmable number of full sweeps, then signals done.

## Interface
- PRECISION_BITS, 4, weight precision; must match the datapath
- OVERFLOW_BITS, 4, extra field bits; PAD = PRECISION_BITS+OVERFLOW_BITS
- NUM_NODES, 4, number of nodes
- NUM_NODES_BIT, 2, width of node index
- NUM_COLORS, 4, number of legal colours; codes ≥ NUM_COLORS are illegal
- NUM_COLORS_BITS, 2, bits per node colour (B)
- SWEEP_BITS, 16, width of sweep counter
- clk  in  1  clock; one clock domain; reset is asynchronous and active-high
- rst  in  1  asynchronous active-high reset
- load  in  1  IDLE only: nodes <= init_nodes
- init_nodes  in  NUM_NODES*B  initial colour vector
- start  in  1  IDLE only: begin annealing run
- num_sweeps  in  SWEEP_BITS  sweeps to run, sampled at start
- noise  in  PAD+1 signed  RNG sample; must be held valid in WRITE cycles
- product  in  PAD signed  local field from datapath for current node/bit
- node_count  out  NUM_NODES_BIT  node index to datapath
- color_bit_count  out  log2(B)  colour-bit index to datapath
- nodes  out  NUM_NODES*B  colour register; node i at bits [(i+1)B-1 : iB]
- busy  out  1  high from EVAL entry until DONE
- done  out  1  single-cycle pulse at completion
- sweep_count  out  SWEEP_BITS  completed sweeps in current run

## Operation
- States: IDLE, EVAL, WRITE, FIX, DONE.
- IDLE: load takes priority over start in the same cycle. Start latches num_sweeps, clears sweep_count, node_count and color_bit_count. If num_sweeps==0 go DONE, else go EVAL.
- EVAL: indices are stable; field_q <= product (registered, breaking the adder-tree path); go WRITE.
- WRITE: sum = sext(field_q, PAD+1) + noise, computed at PAD+2 bits so it cannot overflow. Bit = (sum > 0) strictly; sum==0 gives 0. Write bit to nodes[node_count*B + color_bit_count].
  - If color_bit_count < B-1: increment it, go EVAL.
  - Else: go FIX.
- FIX: if the colour of node node_count is ≥ NUM_COLORS, clamp it to NUM_COLORS-1. Reset color_bit_count to 0.
  - If node_count < NUM_NODES-1: increment it, go EVAL.
  - Else: node_count <= 0 and sweep_count++. If the new sweep_count == num_sweeps go DONE, else go EVAL.
- DONE: done=1 and busy=0 for one cycle, then IDLE.
- start or load outside IDLE: ignored. nodes changes only in WRITE, FIX or via load.

## Timing
- Reset values: nodes=0, node_count=0, color_bit_count=0, sweep_count=0, busy=0, done=0, state IDLE. Reset applies immediately, even mid-sweep.
- Start sampled at edge 0 → EVAL in cycle 1, busy=1 from cycle 1.
- Per bit: 2 cycles (EVAL, WRITE). Per node: 2B+1 cycles. Per sweep: NUM_NODES*(2B+1) cycles, which is 20 at the defaults.
- done is high in cycle 1 + S*NUM_NODES*(2B+1). At the defaults with S=1 that is cycle 21. With S=0, done is high in cycle 1.
- Datapath contract: product must reflect the current nodes, node_count and color_bit_count combinationally within one cycle. A WRITE updates nodes before the next EVAL, so later bits see the new colours (Gibbs-style sequential update).
- sweep_count holds its final value after DONE until the next start or rst.

## Test plan
- Defaults, load 0x00, product=+5, noise=0, num_sweeps=1 → nodes=0xFF; done pulses at cycle 21 after start; busy high for cycles 1–20.
- product=-1, noise=0, init 0xFF, num_sweeps=2 → nodes=0x00; sweep_count=2; done at cycle 41.
- product=+2, noise=-2 (sum=0) → every bit written 0; product=+2, noise=-1 → every bit written 1.
- NUM_COLORS=3, product=+5, noise=0 → every node clamped in FIX to 2'b10; nodes=0xAA.
- rst asserted at cycle 7 of a run → all outputs return to reset values asynchronously. A later start completes normally from nodes=0.
- num_sweeps=0 → done at cycle 1 and nodes unchanged. start or load pulsed while busy → ignored, with identical final nodes and done timing.
